regfile_dump_reader: RTL and testbench



---
 rtl/regfile_dump_reader_if.sv | 51 +++++
 rtl/regfile_dump_reader.sv | 131 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module : regfile_dump_reader_if
// Brief  : Dump control, register-file read port and beat stream signals.
// Rev    : 1.0 - initial release
// ============================================================================
interface regfile_dump_reader_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM_BIT = 5
);
    logic                   start;
    logic                   busy;
    logic                   stall_req;
    logic                   done;
    logic [REG_NUM_BIT-1:0] rf_raddr;
    logic [DATA_WIDTH-1:0]  rf_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [REG_NUM_BIT-1:0] out_idx;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_last;

    modport master (
        input  start,
        input  rf_rdata,
        input  out_ready,
        output busy,
        output stall_req,
        output done,
        output rf_raddr,
        output out_valid,
        output out_idx,
        output out_data,
        output out_last
    );

    modport slave (
        output start,
        output rf_rdata,
        output out_ready,
        input  busy,
        input  stall_req,
        input  done,
        input  rf_raddr,
        input  out_valid,
        input  out_idx,
        input  out_data,
        input  out_last
    );
endinterface
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module : regfile_dump_reader
// Brief  : Walks every GPR through a spare read port and streams (idx, value)
//          beats on valid/ready while holding the core stalled.
// Rev    : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 32,
    parameter int REG_NUM_BIT = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    regfile_dump_reader_if.master  bus
);

    localparam logic [REG_NUM_BIT-1:0] c_last_idx = REG_NUM_BIT'(REG_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [REG_NUM_BIT-1:0] idx_q,       idx_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q,  out_last_d;
    logic [REG_NUM_BIT-1:0] out_idx_q,   out_idx_d;
    logic [DATA_WIDTH-1:0]  out_data_q,  out_data_d;
    logic                   done_q,      done_d;

    logic w_handshake;
    logic w_load;
    logic w_at_last;

    assign w_handshake = out_valid_q & bus.out_ready;
    // The single beat register refills when empty or when its beat is leaving.
    assign w_load      = ~out_valid_q | bus.out_ready;
    assign w_at_last   = (idx_q == c_last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                end
            end

            S_RUN: begin
                if (w_load) begin
                    out_valid_d = 1'b1;
                    out_idx_d   = idx_q;
                    // x0 is architecturally zero whatever the array holds.
                    out_data_d  = (idx_q == '0) ? '0 : bus.rf_rdata;
                    out_last_d  = w_at_last;
                    if (w_at_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + REG_NUM_BIT'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (w_handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    idx_d       = '0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.stall_req = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.rf_raddr  = idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

`ifndef SYNTHESIS
    a_payload_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !bus.out_ready) |=>
            (out_valid_q && $stable(out_idx_q) && $stable(out_data_q) && $stable(out_last_q)));

    a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        (idx_q <= c_last_idx));
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_dump_reader
// Brief  : Directed vector table plus dump sequences for regfile_dump_reader.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

    localparam int DATA_WIDTH  = 32;
    localparam int REG_NUM     = 32;
    localparam int REG_NUM_BIT = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    regfile_dump_reader_if #(.DATA_WIDTH(DATA_WIDTH), .REG_NUM_BIT(REG_NUM_BIT)) bus ();

    regfile_dump_reader #(
        .DATA_WIDTH  (DATA_WIDTH),
        .REG_NUM     (REG_NUM),
        .REG_NUM_BIT (REG_NUM_BIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: x0 storage deliberately non-zero.
    always_comb begin
        if (bus.rf_raddr == '0) bus.rf_rdata = 32'hDEAD;
        else                    bus.rf_rdata = 32'h1000 + 32'(bus.rf_raddr);
    end

    function automatic logic [31:0] exp_data(input int k);
        return (k == 0) ? 32'h0 : 32'h1000 + 32'(k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        start;
        logic        ready;
        logic        busy;
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
        logic [4:0]  raddr;
        logic        done;
    } vec_t;

    vec_t vecs[8];

    // mode 0: ready=1, 1: random ready, 2: restart at beat 10, 3: 20-cycle stall
    task automatic do_dump(input int mode, input bit tail);
        int k;
        int cyc;
        int busy_cnt;
        bit stalled;
        bit hs;
        bit saw_done;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk($sformatf("m%0d busy after start", mode), bus.busy, 1);
        chk($sformatf("m%0d stall after start", mode), bus.stall_req, 1);
        chk($sformatf("m%0d no beat at E0", mode), bus.out_valid, 0);
        busy_cnt = 1; k = 0; cyc = 0; saw_done = 0;
        while (!saw_done && cyc < 400) begin
            case (mode)
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                3:       bus.out_ready = !(cyc >= 1 && cyc <= 20);
                default: bus.out_ready = 1'b1;
            endcase
            if (mode == 2 && k == 10 && bus.out_valid) bus.start = 1'b1;
            stalled = bus.out_valid && !bus.out_ready;
            hs      = bus.out_valid && bus.out_ready;
            if (hs) begin
                chk($sformatf("m%0d beat%0d idx", mode, k), bus.out_idx, k);
                chk($sformatf("m%0d beat%0d data", mode, k), bus.out_data, exp_data(k));
                chk($sformatf("m%0d beat%0d last", mode, k), bus.out_last, (k == REG_NUM - 1));
                k++;
            end
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
            if (cyc == 1) chk($sformatf("m%0d first beat valid", mode), bus.out_valid, 1);
            if (stalled) begin
                chk($sformatf("m%0d hold valid k%0d", mode, k), bus.out_valid, 1);
                chk($sformatf("m%0d hold idx k%0d", mode, k), bus.out_idx, k);
                chk($sformatf("m%0d hold data k%0d", mode, k), bus.out_data, exp_data(k));
                chk($sformatf("m%0d hold last k%0d", mode, k), bus.out_last, (k == REG_NUM - 1));
                chk($sformatf("m%0d hold raddr k%0d", mode, k), bus.rf_raddr,
                    (k == REG_NUM - 1) ? REG_NUM - 1 : k + 1);
            end
            chk($sformatf("m%0d busy c%0d", mode, cyc), bus.busy, (k < REG_NUM));
            chk($sformatf("m%0d stall_req c%0d", mode, cyc), bus.stall_req, (k < REG_NUM));
            chk($sformatf("m%0d done c%0d", mode, cyc), bus.done, (k == REG_NUM));
            if (bus.busy) busy_cnt++;
            if (bus.done) saw_done = 1'b1;
        end
        if (!saw_done) chk($sformatf("m%0d done timeout", mode), 0, 1);
        chk($sformatf("m%0d beat count", mode), k, REG_NUM);
        if (mode == 0) chk("busy cycles", busy_cnt, 33);
        if (tail) begin
            @(posedge clk); #1;
            chk($sformatf("m%0d done one cycle", mode), bus.done, 0);
            chk($sformatf("m%0d idle busy", mode), bus.busy, 0);
            chk($sformatf("m%0d idle valid", mode), bus.out_valid, 0);
            chk($sformatf("m%0d idle raddr", mode), bus.rf_raddr, 0);
        end
    endtask

    initial begin
        int guard;
        n_checks = 0;
        n_fail   = 0;

        //            start ready busy valid idx  data          last raddr done
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0,        1'b0, 5'd1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0,        1'b0, 5'd1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h1001,     1'b0, 5'd2, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h1001,     1'b0, 5'd2, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h1001,     1'b0, 5'd2, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h1002,     1'b0, 5'd3, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h1003,     1'b0, 5'd4, 1'b0};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst busy", bus.busy, 0);
        chk("rst stall_req", bus.stall_req, 0);
        chk("rst done", bus.done, 0);
        chk("rst valid", bus.out_valid, 0);
        chk("rst last", bus.out_last, 0);
        chk("rst idx", bus.out_idx, 0);
        chk("rst data", bus.out_data, 0);
        chk("rst raddr", bus.rf_raddr, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus.start     = vecs[i].start;
            bus.out_ready = vecs[i].ready;
            @(posedge clk); #1;
            bus.start = 1'b0;
            chk($sformatf("v%0d busy", i), bus.busy, vecs[i].busy);
            chk($sformatf("v%0d stall_req", i), bus.stall_req, vecs[i].busy);
            chk($sformatf("v%0d valid", i), bus.out_valid, vecs[i].valid);
            chk($sformatf("v%0d idx", i), bus.out_idx, vecs[i].idx);
            chk($sformatf("v%0d data", i), bus.out_data, vecs[i].data);
            chk($sformatf("v%0d last", i), bus.out_last, vecs[i].last);
            chk($sformatf("v%0d raddr", i), bus.rf_raddr, vecs[i].raddr);
            chk($sformatf("v%0d done", i), bus.done, vecs[i].done);
        end

        // Run on to beat 15, then pull reset between edges.
        bus.out_ready = 1'b1;
        guard = 0;
        while (!(bus.out_valid && bus.out_idx == 5'd15) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach beat 15", bus.out_idx, 15);
        #3 rst_n = 1'b0;
        #1;
        chk("abort valid", bus.out_valid, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort stall_req", bus.stall_req, 0);
        chk("abort done", bus.done, 0);
        chk("abort raddr", bus.rf_raddr, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-abort done", bus.done, 0);
        chk("post-abort busy", bus.busy, 0);

        do_dump(0, 1'b0);
        do_dump(0, 1'b1);
        do_dump(1, 1'b1);
        do_dump(2, 1'b1);
        do_dump(3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
